// File: rtl/can_tx_mailbox_scheduler_if.sv
// rtl/can_tx_mailbox_scheduler_if.sv - mailbox request and bit-stuffer handshake bundle
interface can_tx_mailbox_scheduler_if #(
  parameter int N_MBOX = 4
);
  logic [N_MBOX-1:0]    req_i;
  logic [N_MBOX*11-1:0] id_i;
  logic [N_MBOX*32-1:0] data_i;
  logic [N_MBOX-1:0]    ack_o;
  logic                 err_o;
  logic                 busy_o;
  logic [65:0]          unstuffed_o;
  logic                 stuf_start_o;
  logic                 stuf_done_i;

  modport slave (
    input  req_i, id_i, data_i, stuf_done_i,
    output ack_o, err_o, busy_o, unstuffed_o, stuf_start_o
  );

  modport master (
    output req_i, id_i, data_i, stuf_done_i,
    input  ack_o, err_o, busy_o, unstuffed_o, stuf_start_o
  );
endinterface

// File: rtl/can_tx_mailbox_scheduler.sv
// rtl/can_tx_mailbox_scheduler.sv - lowest-ID mailbox arbiter, CRC-15 frame builder and stuffer sequencer
module can_tx_mailbox_scheduler #(
  parameter int N_MBOX       = 4,
  parameter int IDX_W        = $clog2(N_MBOX),
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  can_tx_mailbox_scheduler_if.slave     bus
);
  localparam int TMR_W = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_CRC, S_LAUNCH, S_WAIT, S_ACK} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [50:0]        r_hdr;
  logic [14:0]        r_crc;
  logic [5:0]         r_cnt;
  logic [TMR_W-1:0]   r_timer;
  logic [N_MBOX-1:0]  r_ack;
  logic               r_err;
  logic               r_busy;
  logic               r_start;
  logic [65:0]        r_unstuffed;

  logic               w_any;
  logic [IDX_W-1:0]   w_win_idx;
  logic [10:0]        w_win_id;
  logic [31:0]        w_win_data;
  logic               w_bit;
  logic               w_fb;
  logic [14:0]        w_crc_nxt;

  // Strict less-than keeps the lowest index on equal IDs.
  always_comb begin
    w_any      = 1'b0;
    w_win_idx  = '0;
    w_win_id   = '0;
    w_win_data = '0;
    for (int k = 0; k < N_MBOX; k++) begin
      if (bus.req_i[k] && (!w_any || bus.id_i[11*k +: 11] < w_win_id)) begin
        w_any      = 1'b1;
        w_win_idx  = IDX_W'(k);
        w_win_id   = bus.id_i[11*k +: 11];
        w_win_data = bus.data_i[32*k +: 32];
      end
    end
  end

  assign w_bit     = r_hdr[6'd50 - r_cnt];
  assign w_fb      = w_bit ^ r_crc[14];
  assign w_crc_nxt = {r_crc[13:0], 1'b0} ^ (w_fb ? 15'h4599 : 15'h0000);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_hdr       <= '0;
      r_crc       <= '0;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_unstuffed <= '0;
    end else begin
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_win_idx;
            r_hdr   <= {1'b0, w_win_id, 3'b000, 4'd4, w_win_data};
            r_cnt   <= '0;
            r_crc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CRC;
          end
        end
        S_CRC: begin
          r_crc <= w_crc_nxt;
          r_cnt <= r_cnt + 6'd1;
          // Outputs are registered, so the LAUNCH values are loaded on the way in.
          if (r_cnt == 6'd50) begin
            r_unstuffed <= {r_hdr, w_crc_nxt};
            r_start     <= 1'b1;
            r_timer     <= '0;
            r_state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_timer <= r_timer + TMR_W'(1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.stuf_done_i) begin
            r_ack[r_idx] <= 1'b1;
            r_state      <= S_ACK;
          end else if (r_timer == TMR_W'(WAIT_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_ACK: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ack_o        = r_ack;
  assign bus.err_o        = r_err;
  assign bus.busy_o       = r_busy;
  assign bus.stuf_start_o = r_start;
  assign bus.unstuffed_o  = r_unstuffed;
endmodule

// File: tb/tb_can_tx_mailbox_scheduler.sv
// tb/tb_can_tx_mailbox_scheduler.sv - directed bench with a timeline model of the CAN TX scheduler
module tb_can_tx_mailbox_scheduler;
  localparam int WT = 255;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_err;
  int   n_starts;
  int   n_acks;

  can_tx_mailbox_scheduler_if #(.N_MBOX(4)) bus ();

  can_tx_mailbox_scheduler #(.N_MBOX(4), .WAIT_TIMEOUT(WT)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [65:0] mk_frame(input logic [10:0] id, input logic [31:0] d);
    logic [50:0] h;
    logic [14:0] c;
    logic        b;
    h = {1'b0, id, 3'b000, 4'd4, d};
    c = '0;
    for (int i = 50; i >= 0; i--) begin
      b = h[i] ^ c[14];
      c = {c[13:0], 1'b0} ^ (b ? 15'h4599 : 15'h0000);
    end
    return {h, c};
  endfunction

  // Timeline model: m_el counts periods since the request was taken.
  logic        m_act, m_acking;
  int          m_el, m_idx, best;
  logic [65:0] m_frame;
  logic        e_busy, e_start, e_err;
  logic [3:0]  e_ack;
  logic [65:0] e_unst;

  initial begin
    m_act = 0; m_acking = 0; m_el = 0; m_idx = 0; m_frame = '0;
    e_busy = 0; e_start = 0; e_err = 0; e_ack = '0; e_unst = '0;
  end

  always @(posedge clk) begin
    e_start = 1'b0;
    e_ack   = '0;
    e_err   = 1'b0;
    if (rst) begin
      m_act = 0; m_acking = 0; e_busy = 0; e_unst = '0;
    end else if (!m_act) begin
      best = -1;
      for (int k = 0; k < 4; k++)
        if (bus.req_i[k] && (best < 0 || bus.id_i[11*k +: 11] < bus.id_i[11*best +: 11]))
          best = k;
      if (best >= 0) begin
        m_idx   = best;
        m_frame = mk_frame(bus.id_i[11*best +: 11], bus.data_i[32*best +: 32]);
        m_act   = 1; m_el = 1; e_busy = 1;
      end
    end else if (m_acking) begin
      m_act = 0; m_acking = 0; e_busy = 0;
    end else if (m_el >= 53 && bus.stuf_done_i) begin
      m_acking = 1; e_ack[m_idx] = 1'b1;
    end else if (m_el == 52 + WT - 1) begin
      e_err = 1; m_act = 0; e_busy = 0;
    end else begin
      m_el++;
      if (m_el == 52) begin
        e_start = 1; e_unst = m_frame;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {65'd0, bus.busy_o}, {65'd0, e_busy});
    chk("start", {65'd0, bus.stuf_start_o}, {65'd0, e_start});
    chk("err", {65'd0, bus.err_o}, {65'd0, e_err});
    chk("ack", {62'd0, bus.ack_o}, {62'd0, e_ack});
    chk("unstuffed", bus.unstuffed_o, e_unst);
    if (bus.stuf_start_o) n_starts++;
    if (|bus.ack_o) n_acks++;
  end

  // Stuffer stand-in: done stuf_delay periods after start, plus on-demand stray pulses.
  logic stuf_en;
  int   stuf_delay, stray_total, s_cnt, s_seen;
  initial begin
    bus.stuf_done_i = 1'b0;
    s_cnt = 0; s_seen = 0;
    forever begin
      @(posedge clk); #2;
      bus.stuf_done_i = 1'b0;
      if (s_cnt > 0) begin
        s_cnt--;
        if (s_cnt == 0) bus.stuf_done_i = 1'b1;
      end
      if (bus.stuf_start_o && stuf_en) s_cnt = stuf_delay;
      if (stray_total != s_seen) begin
        bus.stuf_done_i = 1'b1;
        s_seen = stray_total;
      end
    end
  end

  // kind: 0 = start, 1 = ack, 2 = err
  task automatic wait_ev(input int kind, input int limit, input string name,
                         output int at, output logic [3:0] av);
    logic hit;
    hit = 1'b0; at = -1; av = '0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      if ((kind == 0 && bus.stuf_start_o) || (kind == 1 && |bus.ack_o) || (kind == 2 && bus.err_o)) begin
        hit = 1'b1; at = cyc; av = bus.ack_o;
      end
    end
    if (!hit) begin
      n_checks++; n_err++;
      $display("FAIL %s: event %0d not seen within %0d cycles", name, kind, limit);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int         t_req, t_s, t_s2, t_a, t_e, snap;
  logic [3:0] av;

  initial begin
    n_checks = 0; n_err = 0; n_starts = 0; n_acks = 0;
    rst = 1'b1; stuf_en = 1'b1; stuf_delay = 20; stray_total = 0;
    bus.req_i = '0; bus.id_i = '0; bus.data_i = '0;
    tick(3);
    @(negedge clk);
    chk("rst_busy", {65'd0, bus.busy_o}, 66'd0);
    chk("rst_unst", bus.unstuffed_o, 66'd0);
    chk("rst_ack", {62'd0, bus.ack_o}, 66'd0);
    tick(1); rst = 1'b0;
    tick(2);

    // 1: single frame, latency and layout
    bus.id_i[10:0] = 11'h123; bus.data_i[31:0] = 32'hDEADBEEF; bus.req_i = 4'b0001; t_req = cyc;
    wait_ev(0, 200, "t1_start", t_s, av);
    chk("t1_latency", 66'(t_s - t_req), 66'd52);
    chk("t1_hdr", {15'd0, bus.unstuffed_o[65:15]}, {15'd0, 51'h9184DEADBEEF});
    chk("t1_model_hdr", {15'd0, m_frame[65:15]}, {15'd0, 51'h9184DEADBEEF});
    chk("t1_crc", {51'd0, bus.unstuffed_o[14:0]}, {51'd0, m_frame[14:0]});
    wait_ev(1, 100, "t1_ack", t_a, av);
    chk("t1_ack_val", {62'd0, av}, 66'b0001);
    chk("t1_ack_lat", 66'(t_a - t_s), 66'd21);
    bus.req_i[0] = 1'b0;
    tick(3);

    // 2: lower ID on higher index wins, then back-to-back
    bus.id_i[21:11] = 11'h200; bus.id_i[43:33] = 11'h100;
    bus.data_i[63:32] = 32'h11112222; bus.data_i[127:96] = 32'h33334444;
    bus.req_i = 4'b1010;
    wait_ev(1, 200, "t2_ack1", t_a, av);
    chk("t2_ack1_val", {62'd0, av}, 66'b1000);
    bus.req_i[3] = 1'b0;
    wait_ev(0, 200, "t2_start2", t_s2, av);
    chk("t2_gap", 66'(t_s2 - t_a), 66'd53);
    wait_ev(1, 100, "t2_ack2", t_a, av);
    chk("t2_ack2_val", {62'd0, av}, 66'b0010);
    bus.req_i[1] = 1'b0;
    tick(3);

    // 3: equal IDs, lowest index first
    bus.id_i[10:0] = 11'h055; bus.id_i[32:22] = 11'h055; bus.data_i[95:64] = 32'hA5A5A5A5;
    bus.req_i = 4'b0101;
    wait_ev(1, 200, "t3_ack1", t_a, av);
    chk("t3_ack1_val", {62'd0, av}, 66'b0001);
    bus.req_i[0] = 1'b0;
    wait_ev(1, 200, "t3_ack2", t_a, av);
    chk("t3_ack2_val", {62'd0, av}, 66'b0100);
    bus.req_i[2] = 1'b0;
    tick(3);

    // 4: stuffer timeout, then resend
    stuf_en = 1'b0;
    bus.id_i[21:11] = 11'h321; bus.req_i = 4'b0010;
    wait_ev(0, 200, "t4_start", t_s, av);
    snap = n_acks;
    wait_ev(2, 400, "t4_err", t_e, av);
    chk("t4_err_lat", 66'(t_e - t_s), 66'(WT));
    chk("t4_no_ack", 66'(n_acks - snap), 66'd0);
    stuf_en = 1'b1;
    wait_ev(0, 200, "t4_restart", t_s2, av);
    chk("t4_restart_lat", 66'(t_s2 - t_e), 66'd52);
    wait_ev(1, 100, "t4_ack", t_a, av);
    chk("t4_ack_val", {62'd0, av}, 66'b0010);
    bus.req_i[1] = 1'b0;
    tick(3);

    // 5: reset at CRC count 20
    bus.id_i[32:22] = 11'h0AA; bus.data_i[95:64] = 32'h12345678; bus.req_i = 4'b0100; t_req = cyc;
    snap = n_starts + n_acks;
    tick(21); rst = 1'b1;
    @(negedge clk);
    chk("t5_busy_pre", {65'd0, bus.busy_o}, 66'd1);
    tick(1);
    @(negedge clk);
    chk("t5_busy", {65'd0, bus.busy_o}, 66'd0);
    chk("t5_unst", bus.unstuffed_o, 66'd0);
    chk("t5_no_ev", 66'(n_starts + n_acks - snap), 66'd0);
    tick(1); rst = 1'b0; t_req = cyc;
    wait_ev(0, 200, "t5_start", t_s, av);
    chk("t5_latency", 66'(t_s - t_req), 66'd52);
    chk("t5_frame", bus.unstuffed_o, mk_frame(11'h0AA, 32'h12345678));
    wait_ev(1, 100, "t5_ack", t_a, av);
    chk("t5_ack_val", {62'd0, av}, 66'b0100);
    bus.req_i[2] = 1'b0;
    tick(3);

    // 6: data change and req drop mid-CRC, stray done ignored
    bus.id_i[21:11] = 11'h010; bus.data_i[63:32] = 32'hCAFEF00D; bus.req_i = 4'b0010;
    tick(10);
    bus.data_i[63:32] = 32'h0BADF00D; bus.req_i = 4'b0000; stray_total++;
    wait_ev(0, 200, "t6_start", t_s, av);
    chk("t6_data", {34'd0, bus.unstuffed_o[46:15]}, {34'd0, 32'hCAFEF00D});
    chk("t6_id", {55'd0, bus.unstuffed_o[64:54]}, {55'd0, 11'h010});
    wait_ev(1, 100, "t6_ack", t_a, av);
    chk("t6_ack_val", {62'd0, av}, 66'b0010);
    tick(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
